// File: rtl/reproductor_registro_pkg.sv
// Shared types and widths for the sample playback sequencer.
package reproductor_pkg;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 5;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SHOW, FIN} estado_t;
endpackage

// File: rtl/reproductor_registro_if.sv
// Indexed-read link between the playback sequencer and the circular sample register.
interface reproductor_registro_if;
  import reproductor_pkg::*;

  logic [IDX_W-1:0]  REGposicion;
  logic [IDX_W:0]    REGContador;
  logic [DATA_W-1:0] leer_data;
  logic              valor_leer_listo;
  logic              leer_ahora;
  logic [IDX_W-1:0]  leer_index;

  modport master (
    input  REGposicion, REGContador, leer_data, valor_leer_listo,
    output leer_ahora, leer_index
  );

  modport slave (
    output REGposicion, REGContador, leer_data, valor_leer_listo,
    input  leer_ahora, leer_index
  );
endinterface

// File: rtl/reproductor_registro_contador_permanencia.sv
// Loadable down-counter timing how long each sample stays on display.
module contador_permanencia #(
  parameter int unsigned T_MOSTRAR = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cargar,
  input  logic decrementar,
  output logic cero
);
  localparam int unsigned W = $clog2(T_MOSTRAR + 1);

  logic [W-1:0] cuenta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cuenta <= '0;
    end else if (cargar) begin
      cuenta <= W'(T_MOSTRAR - 1);
    end else if (decrementar && (cuenta != '0)) begin
      cuenta <= cuenta - 1'b1;
    end
  end

  assign cero = (cuenta == '0);
endmodule

// File: rtl/reproductor_registro.sv
// Playback sequencer: snapshots the circular register, then shows each sample
// oldest-to-newest for T_MOSTRAR cycles, optionally looping.
module reproductor_registro
  import reproductor_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned T_MOSTRAR = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  iniciar,
  input  logic                  detener,
  input  logic                  repetir,
  reproductor_registro_if.master reg_bus,
  output logic [DATA_W-1:0]     dato_mostrar,
  output logic                  dato_valido,
  output logic [IDX_W-1:0]      indice_actual,
  output logic                  ocupado,
  output logic                  terminado
);
  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   PROF   = (IDX_W + 1)'(N);

  estado_t           estado, estado_n;
  logic [IDX_W:0]    cnt, cnt_n;
  logic [IDX_W-1:0]  inicio, inicio_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [IDX_W-1:0]  ord, ord_n;
  logic [DATA_W-1:0] dato_n;
  logic              leer_ahora_q;
  logic [IDX_W-1:0]  inicio_snap;
  logic              cargar, decrementar, cero, abortar;

  // Not yet wrapped: oldest sample sits in slot 0; otherwise at the write slot.
  assign inicio_snap = (reg_bus.REGContador < PROF) ? '0 : reg_bus.REGposicion;
  assign abortar     = detener && (estado inside {REQ, WAIT, SHOW});

  contador_permanencia #(.T_MOSTRAR(T_MOSTRAR)) u_permanencia (
    .clk         (clk),
    .reset_n     (reset_n),
    .cargar      (cargar),
    .decrementar (decrementar),
    .cero        (cero)
  );

  always_comb begin
    estado_n    = estado;
    cnt_n       = cnt;
    inicio_n    = inicio;
    idx_n       = idx;
    ord_n       = ord;
    dato_n      = dato_mostrar;
    cargar      = 1'b0;
    decrementar = 1'b0;
    if (abortar) begin
      estado_n = FIN;
    end else begin
      unique case (estado)
        IDLE: begin
          if (iniciar) begin
            cnt_n    = reg_bus.REGContador;
            inicio_n = inicio_snap;
            idx_n    = inicio_snap;
            ord_n    = '0;
            estado_n = (reg_bus.REGContador == '0) ? FIN : REQ;
          end
        end
        REQ: estado_n = WAIT;
        WAIT: begin
          if (reg_bus.valor_leer_listo) begin
            dato_n   = reg_bus.leer_data;
            cargar   = 1'b1;
            estado_n = SHOW;
          end
        end
        SHOW: begin
          decrementar = 1'b1;
          if (cero) begin
            if ({1'b0, ord} == (cnt - 1'b1)) begin
              if (repetir) begin
                cnt_n    = reg_bus.REGContador;
                inicio_n = inicio_snap;
                idx_n    = inicio_snap;
                ord_n    = '0;
                estado_n = (reg_bus.REGContador == '0) ? FIN : REQ;
              end else begin
                estado_n = FIN;
              end
            end else begin
              idx_n    = (idx == ULTIMO) ? '0 : idx + 1'b1;
              ord_n    = ord + 1'b1;
              estado_n = REQ;
            end
          end
        end
        FIN:     estado_n = IDLE;
        default: estado_n = IDLE;
      endcase
    end
  end

  // Status flags are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado       <= IDLE;
      cnt          <= '0;
      inicio       <= '0;
      idx          <= '0;
      ord          <= '0;
      dato_mostrar <= '0;
      leer_ahora_q <= 1'b0;
      dato_valido  <= 1'b0;
      ocupado      <= 1'b0;
      terminado    <= 1'b0;
    end else begin
      estado       <= estado_n;
      cnt          <= cnt_n;
      inicio       <= inicio_n;
      idx          <= idx_n;
      ord          <= ord_n;
      dato_mostrar <= dato_n;
      leer_ahora_q <= (estado_n == REQ);
      dato_valido  <= (estado_n == SHOW);
      ocupado      <= (estado_n != IDLE);
      terminado    <= (estado_n == FIN);
    end
  end

  assign reg_bus.leer_ahora = leer_ahora_q;
  assign reg_bus.leer_index = idx;
  assign indice_actual      = ord;
endmodule

// File: tb/tb_reproductor_registro.sv
// Bench for reproductor_registro with a behavioural circular register upstream.
module tb_reproductor_registro;
  localparam int N = 4;
  localparam int T = 3;

  logic clk = 1'b0;
  logic reset_n, iniciar, detener, repetir;
  logic [15:0] dato_mostrar;
  logic        dato_valido, ocupado, terminado;
  logic [4:0]  indice_actual;

  always #5 clk = ~clk;

  reproductor_registro_if bus();

  reproductor_registro #(.N(N), .T_MOSTRAR(T)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .iniciar       (iniciar),
    .detener       (detener),
    .repetir       (repetir),
    .reg_bus       (bus),
    .dato_mostrar  (dato_mostrar),
    .dato_valido   (dato_valido),
    .indice_actual (indice_actual),
    .ocupado       (ocupado),
    .terminado     (terminado)
  );

  // Upstream circular register model
  logic [15:0] mem [N];
  logic [4:0]  wpos;
  logic [5:0]  wcnt;
  logic [15:0] hist[$];
  assign bus.REGposicion = wpos;
  assign bus.REGContador = wcnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.valor_leer_listo <= 1'b0;
      bus.leer_data        <= '0;
    end else begin
      bus.valor_leer_listo <= bus.leer_ahora;
      bus.leer_data        <= mem[bus.leer_index];
    end
  end

  int tests = 0;
  int fails = 0;
  int shows, run, term_cnt, first_idx;
  bit first_seen, skip_len;
  logic [4:0]  exp_idx[$];
  logic [15:0] exp_dat[$];
  logic [4:0]  exp_ord[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      run = 0;
    end else begin
      if (bus.leer_ahora) begin
        if (!first_seen) begin
          first_idx  = int'(bus.leer_index);
          first_seen = 1'b1;
        end
        if (exp_idx.size() == 0) flag_fail("unexpected_read");
        else chk("leer_index", 32'(bus.leer_index), 32'(exp_idx.pop_front()));
      end
      if (dato_valido) begin
        if (run == 0) begin
          shows++;
          if (exp_dat.size() == 0) flag_fail("unexpected_show");
          else begin
            chk("dato_mostrar", 32'(dato_mostrar), 32'(exp_dat.pop_front()));
            chk("indice_actual", 32'(indice_actual), 32'(exp_ord.pop_front()));
          end
        end
        run++;
      end else begin
        if (run != 0) begin
          if (!skip_len) chk("dwell_len", 32'(run), 32'(T));
          skip_len = 1'b0;
        end
        run = 0;
      end
      if (terminado) term_cnt++;
    end
  end

  task automatic clear_model();
    hist.delete();
    wpos = '0;
    wcnt = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  task automatic wr(input logic [15:0] v);
    @(negedge clk);
    mem[wpos] = v;
    hist.push_back(v);
    wpos = (wpos == 5'(N - 1)) ? 5'd0 : wpos + 5'd1;
    if (wcnt < 6'(N)) wcnt = wcnt + 6'd1;
  endtask

  // Oldest-to-newest expectations come from write history, not slot layout.
  task automatic push_pass();
    int c, s;
    c = int'(wcnt);
    s = (wcnt < 6'(N)) ? 0 : int'(wpos);
    for (int j = 0; j < c; j++) begin
      exp_idx.push_back(5'((s + j) % N));
      exp_dat.push_back(hist[hist.size() - c + j]);
      exp_ord.push_back(5'(j));
    end
  endtask

  task automatic new_pass();
    shows = 0; term_cnt = 0; first_seen = 1'b0; first_idx = -1;
  endtask

  task automatic start_pulse();
    @(negedge clk); iniciar = 1'b1;
    @(negedge clk); iniciar = 1'b0;
  endtask

  task automatic wait_term(input int budget);
    int c = 0;
    while (!terminado && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!terminado) flag_fail("terminado_timeout");
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int          nwr;
    logic [15:0] base;
    int          exp_shows;
    int          exp_first_idx;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1, 16'h0100, 1, 0};
    vecs[1] = '{3, 16'h0A00, 3, 0};
    vecs[2] = '{4, 16'h0B00, 4, 0};
    vecs[3] = '{5, 16'h0C00, 4, 1};
    vecs[4] = '{6, 16'h0001, 4, 2};
    vecs[5] = '{9, 16'hF000, 4, 1};

    reset_n = 1'b0; iniciar = 1'b0; detener = 1'b0; repetir = 1'b0;
    clear_model();
    new_pass();
    skip_len = 1'b0; run = 0;
    repeat (2) @(negedge clk);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_leer_ahora", 32'(bus.leer_ahora), 0);
    chk("rst_dato", 32'(dato_mostrar), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Partial fill with first-transaction timing
    clear_model();
    wr(16'h0011); wr(16'h0022);
    new_pass(); push_pass();
    start_pulse();
    chk("t1_leer_ahora", 32'(bus.leer_ahora), 1);
    chk("t1_leer_index", 32'(bus.leer_index), 0);
    chk("t1_ocupado", 32'(ocupado), 1);
    @(negedge clk);
    chk("t2_wait_valido", 32'(dato_valido), 0);
    chk("t2_leer_ahora", 32'(bus.leer_ahora), 0);
    @(negedge clk);
    chk("t3_valido", 32'(dato_valido), 1);
    chk("t3_dato", 32'(dato_mostrar), 32'h0011);
    wait_term(100);
    chk("fin_ocupado", 32'(ocupado), 1);
    @(negedge clk);
    chk("fin_term_low", 32'(terminado), 0);
    chk("fin_ocupado_low", 32'(ocupado), 0);
    settle();
    chk("partial_shows", 32'(shows), 2);
    chk("partial_term", 32'(term_cnt), 1);

    // Table-driven full passes
    for (int i = 0; i < 6; i++) begin
      clear_model();
      for (int j = 0; j < vecs[i].nwr; j++) wr(vecs[i].base + 16'(j));
      new_pass(); push_pass();
      start_pulse();
      wait_term(200);
      settle();
      chk("vec_shows", 32'(shows), 32'(vecs[i].exp_shows));
      chk("vec_first_idx", 32'(first_idx), 32'(vecs[i].exp_first_idx));
      chk("vec_term", 32'(term_cnt), 1);
      chk("vec_drained", 32'(exp_dat.size()), 0);
    end

    // Empty register
    clear_model();
    new_pass();
    start_pulse();
    chk("empty_term", 32'(terminado), 1);
    chk("empty_no_read", 32'(bus.leer_ahora), 0);
    @(negedge clk);
    chk("empty_term_low", 32'(terminado), 0);
    chk("empty_idle", 32'(ocupado), 0);
    settle();
    chk("empty_shows", 32'(shows), 0);

    // Repeat: A,B,A,B,A then drop repetir, stop after B
    clear_model();
    wr(16'h0A0A); wr(16'h0B0B);
    new_pass();
    push_pass(); push_pass(); push_pass();
    repetir = 1'b1;
    start_pulse();
    begin
      int c = 0;
      while (shows < 5 && c < 200) begin @(negedge clk); c++; end
      chk("rep_reached_5", 32'(shows >= 5), 1);
    end
    repetir = 1'b0;
    wait_term(100);
    settle();
    chk("rep_shows", 32'(shows), 6);
    chk("rep_term", 32'(term_cnt), 1);
    chk("rep_drained", 32'(exp_dat.size()), 0);

    // Abort during sample 1
    clear_model();
    wr(16'h1111); wr(16'h2222);
    new_pass(); push_pass();
    start_pulse();
    begin
      int c = 0;
      while (!(dato_valido && indice_actual == 5'd1) && c < 100) begin @(negedge clk); c++; end
    end
    skip_len = 1'b1;
    detener = 1'b1;
    @(negedge clk);
    detener = 1'b0;
    chk("abort_term", 32'(terminado), 1);
    chk("abort_valido", 32'(dato_valido), 0);
    chk("abort_hold", 32'(dato_mostrar), 32'h2222);
    settle();
    chk("abort_term_cnt", 32'(term_cnt), 1);
    chk("abort_idle", 32'(ocupado), 0);

    // Reset mid-WAIT (wrapped fill so leer_index is non-zero)
    clear_model();
    for (int j = 0; j < 5; j++) wr(16'h3300 + 16'(j));
    new_pass(); push_pass();
    start_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_leer_ahora", 32'(bus.leer_ahora), 0);
    chk("arst_leer_index", 32'(bus.leer_index), 0);
    chk("arst_dato", 32'(dato_mostrar), 0);
    chk("arst_valido", 32'(dato_valido), 0);
    chk("arst_indice", 32'(indice_actual), 0);
    chk("arst_ocupado", 32'(ocupado), 0);
    chk("arst_term", 32'(terminado), 0);
    exp_idx.delete(); exp_dat.delete(); exp_ord.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_stay_idle", 32'(ocupado), 0);

    // Ignored start while busy
    clear_model();
    wr(16'h4441); wr(16'h4442); wr(16'h4443);
    new_pass(); push_pass();
    start_pulse();
    begin
      int c = 0;
      while (!dato_valido && c < 50) begin @(negedge clk); c++; end
    end
    iniciar = 1'b1; @(negedge clk); iniciar = 1'b0;
    repeat (4) @(negedge clk);
    iniciar = 1'b1; @(negedge clk); iniciar = 1'b0;
    wait_term(100);
    settle();
    chk("ign_shows", 32'(shows), 3);
    chk("ign_term", 32'(term_cnt), 1);
    chk("ign_drained", 32'(exp_idx.size() + exp_dat.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
